// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN convolution address sequencer.
// Contents: sequencer state encoding, configuration field widths and
// elaboration-time helpers for the scratchpad address width and for
// index widths that must stay at least one bit wide.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int STRIDE_W = 4;
    localparam int NOUT_W   = 8;

    // Scratchpad address width: filter bank plus input region.
    function automatic int calc_aw(input int n, input int flen, input int iw);
        return $clog2(n * flen + iw);
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/cnn_loop_counter.sv
// One level of the nested convolution loop.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - restart the count at zero (takes priority over en)
//   en        - advance one step; wraps to zero after last_val
//   last_val  - terminal count (runtime so the output loop can follow cfg_nout)
//   count     - current count (registered)
//   term      - count is at last_val; gates the enable of the next outer level
module cnn_loop_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] count,
    output logic         term
);

    logic [W-1:0] count_r;

    assign count = count_r;
    assign term  = (count_r == last_val);

    // Count register: clear on reset/load, wrap at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            if (term) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1'b1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/cnn_conv_seq.sv
// Convolution address sequencer. A start in IDLE latches the window base,
// filter base, output base, stride and output count, then streams
// N x cfg_nout x FLEN beats (filter outer, output position, tap inner) on a
// valid/ready interface. Addresses are built incrementally from registered
// bases, so every rd_* output is a flop and rd_ready only gates their update.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - launch (sampled in IDLE only)
//   x_inp, y_inp, z_inp   - input window, filter bank and output index bases
//   cfg_stride, cfg_nout  - window stride (0 means 1), output positions/filter
//   busy, done            - running flag, one-cycle completion pulse
//   rd_valid, rd_ready    - beat handshake
//   rd_xaddr, rd_yaddr    - input and filter scratchpad addresses
//   rd_zaddr, rd_fidx     - output index and filter number
//   rd_first, rd_last     - first/last tap of an accumulation
module cnn_conv_seq
    import cnn_pkg::*;
#(
    parameter int N           = 4,
    parameter int FLEN        = 16,
    parameter int INPUT_WORDS = 256,
    parameter int AW          = calc_aw(N, FLEN, INPUT_WORDS),
    parameter int ZW          = NOUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         x_inp,
    input  logic [AW-1:0]         y_inp,
    input  logic [ZW-1:0]         z_inp,
    input  logic [STRIDE_W-1:0]   cfg_stride,
    input  logic [ZW-1:0]         cfg_nout,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [AW-1:0]         rd_xaddr,
    output logic [AW-1:0]         rd_yaddr,
    output logic [ZW-1:0]         rd_zaddr,
    output logic [idx_w(N)-1:0]   rd_fidx,
    output logic                  rd_first,
    output logic                  rd_last
);

    localparam int              KW       = idx_w(FLEN);
    localparam int              FW       = idx_w(N);
    localparam logic [KW-1:0]   K_LAST   = KW'(FLEN - 1);
    localparam logic [KW-1:0]   K_PENULT = KW'((FLEN > 1) ? (FLEN - 2) : 0);
    localparam logic [FW-1:0]   F_LAST   = FW'(N - 1);
    localparam logic [AW-1:0]   FLEN_A   = AW'(FLEN);
    localparam logic            FLEN_ONE = (FLEN == 1) ? 1'b1 : 1'b0;

    state_t state_r, state_next_s;

    logic          accept_s, adv_s;
    logic [KW-1:0] k_cnt_s;
    logic [ZW-1:0] o_cnt_s;
    logic [FW-1:0] f_cnt_s;
    logic          k_term_s, o_term_s, f_term_s;

    logic [AW-1:0] xbase_r, stride_r, win_r, fbase_r;
    logic [ZW-1:0] nout_last_r;
    logic          busy_r, done_r, rd_valid_r;
    logic [AW-1:0] rd_xaddr_r, rd_yaddr_r;
    logic [ZW-1:0] rd_zaddr_r;
    logic          rd_first_r, rd_last_r;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign adv_s    = (state_r == ST_RUN) && rd_valid_r && rd_ready;

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_valid = rd_valid_r;
    assign rd_xaddr = rd_xaddr_r;
    assign rd_yaddr = rd_yaddr_r;
    assign rd_zaddr = rd_zaddr_r;
    assign rd_fidx  = f_cnt_s;
    assign rd_first = rd_first_r;
    assign rd_last  = rd_last_r;

    // Tap loop (innermost): steps on every accepted beat.
    cnn_loop_counter #(.W(KW)) u_k_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .en       (adv_s),
        .last_val (K_LAST),
        .count    (k_cnt_s),
        .term     (k_term_s)
    );

    // Output-position loop: steps when the tap loop wraps.
    cnn_loop_counter #(.W(ZW)) u_o_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .en       (adv_s && k_term_s),
        .last_val (nout_last_r),
        .count    (o_cnt_s),
        .term     (o_term_s)
    );

    // Filter loop (outermost): steps when both inner loops wrap.
    cnn_loop_counter #(.W(FW)) u_f_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .en       (adv_s && k_term_s && o_term_s),
        .last_val (F_LAST),
        .count    (f_cnt_s),
        .term     (f_term_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the final beat is all three loops at their terminals.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_nout != {ZW{1'b0}}) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_FIN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (adv_s && k_term_s && o_term_s && f_term_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they align with the beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            busy_r     <= (state_next_s == ST_RUN);
            done_r     <= (state_next_s == ST_FIN);
            rd_valid_r <= (state_next_s == ST_RUN);
        end
    end

    // Configuration latch and incremental address generation.
    // win_r tracks x_base + o*stride, fbase_r tracks y_base + f*FLEN; the
    // output index simply counts up at each tap-loop wrap because z_base +
    // f*nout + o is contiguous across the o->f rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            xbase_r     <= {AW{1'b0}};
            stride_r    <= {AW{1'b0}};
            win_r       <= {AW{1'b0}};
            fbase_r     <= {AW{1'b0}};
            nout_last_r <= {ZW{1'b0}};
            rd_xaddr_r  <= {AW{1'b0}};
            rd_yaddr_r  <= {AW{1'b0}};
            rd_zaddr_r  <= {ZW{1'b0}};
            rd_first_r  <= 1'b0;
            rd_last_r   <= 1'b0;
        end else if (accept_s) begin
            xbase_r     <= x_inp;
            stride_r    <= (cfg_stride == {STRIDE_W{1'b0}}) ? AW'(1'b1) : AW'(cfg_stride);
            win_r       <= x_inp;
            fbase_r     <= y_inp;
            nout_last_r <= cfg_nout - ZW'(1'b1);
            rd_xaddr_r  <= x_inp;
            rd_yaddr_r  <= y_inp;
            rd_zaddr_r  <= z_inp;
            rd_first_r  <= 1'b1;
            rd_last_r   <= FLEN_ONE;
        end else if (adv_s) begin
            if (!k_term_s) begin
                rd_xaddr_r <= rd_xaddr_r + AW'(1'b1);
                rd_yaddr_r <= rd_yaddr_r + AW'(1'b1);
                rd_first_r <= 1'b0;
                rd_last_r  <= (k_cnt_s == K_PENULT);
            end else begin
                rd_zaddr_r <= rd_zaddr_r + ZW'(1'b1);
                rd_first_r <= 1'b1;
                rd_last_r  <= FLEN_ONE;
                if (!o_term_s) begin
                    win_r      <= win_r + stride_r;
                    rd_xaddr_r <= win_r + stride_r;
                    rd_yaddr_r <= fbase_r;
                end else begin
                    win_r      <= xbase_r;
                    rd_xaddr_r <= xbase_r;
                    fbase_r    <= fbase_r + FLEN_A;
                    rd_yaddr_r <= fbase_r + FLEN_A;
                end
            end
        end else begin
            rd_xaddr_r <= rd_xaddr_r;
            rd_yaddr_r <= rd_yaddr_r;
            rd_zaddr_r <= rd_zaddr_r;
            rd_first_r <= rd_first_r;
            rd_last_r  <= rd_last_r;
        end
    end

endmodule

// File: tb/tb_cnn_conv_seq.sv
// Self-checking bench for cnn_conv_seq. A behavioural model builds the full
// expected beat list from the closed-form address formulas when a start is
// accepted and tracks IDLE/RUN/FIN timing; one negedge process compares the
// DUT against it every cycle. Directed jobs then pin selected beats to
// hand-computed literals.
module tb_cnn_conv_seq;

    localparam int N    = 4;
    localparam int FLEN = 16;
    localparam int AW   = 9;
    localparam int ZW   = 8;
    localparam int MAXB = 4096;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] x_inp = '0, y_inp = '0;
    logic [ZW-1:0] z_inp = '0, cfg_nout = '0;
    logic [3:0]    cfg_stride = '0;
    logic          rd_ready = 1'b0;
    logic          busy, done, rd_valid, rd_first, rd_last;
    logic [AW-1:0] rd_xaddr, rd_yaddr;
    logic [ZW-1:0] rd_zaddr;
    logic [1:0]    rd_fidx;

    cnn_conv_seq #(.N(N), .FLEN(FLEN), .INPUT_WORDS(256)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_inp(x_inp), .y_inp(y_inp), .z_inp(z_inp),
        .cfg_stride(cfg_stride), .cfg_nout(cfg_nout),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_xaddr(rd_xaddr), .rd_yaddr(rd_yaddr), .rd_zaddr(rd_zaddr),
        .rd_fidx(rd_fidx), .rd_first(rd_first), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- model state (written only by the monitor) -------------
    int m_phase = 0;                 // 0 idle, 1 run, 2 fin (state after next edge)
    bit m_known = 1'b0;
    bit exp_busy = 1'b0, exp_done = 1'b0, exp_valid = 1'b0, exp_zero = 1'b0;
    int m_idx = 0, m_total = 0, job_hs = 0, done_cnt = 0;
    int mx [MAXB], my [MAXB], mz [MAXB], mf [MAXB], mfirst [MAXB], mlast [MAXB];
    int ox [MAXB], oy [MAXB], oz [MAXB], of_ [MAXB], ofirst [MAXB], olast [MAXB];

    // Expected beats straight from the formulas, truncated to port widths.
    task automatic build_beats(input int x, input int y, input int z, input int s, input int nout);
        int st;
        int i;
        logic [AW-1:0] tx, ty;
        logic [ZW-1:0] tz;
        st = (s == 0) ? 1 : s;
        m_total = N * nout * FLEN;
        for (int f = 0; f < N; f++) begin
            for (int o = 0; o < nout; o++) begin
                for (int k = 0; k < FLEN; k++) begin
                    i  = (f * nout + o) * FLEN + k;
                    tx = AW'(x + o * st + k);
                    ty = AW'(y + f * FLEN + k);
                    tz = ZW'(z + f * nout + o);
                    mx[i] = int'(tx); my[i] = int'(ty); mz[i] = int'(tz);
                    mf[i] = f; mfirst[i] = (k == 0) ? 1 : 0; mlast[i] = (k == FLEN - 1) ? 1 : 0;
                end
            end
        end
    endtask

    // Compare process: check current outputs, then step the model to the next edge.
    always @(negedge clk) begin
        if (m_known) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("rd_valid", 32'(rd_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("xaddr", 32'(rd_xaddr), 32'(mx[m_idx]));
                check("yaddr", 32'(rd_yaddr), 32'(my[m_idx]));
                check("zaddr", 32'(rd_zaddr), 32'(mz[m_idx]));
                check("fidx", 32'(rd_fidx), 32'(mf[m_idx]));
                check("first", 32'(rd_first), 32'(mfirst[m_idx]));
                check("last", 32'(rd_last), 32'(mlast[m_idx]));
            end else if (exp_zero) begin
                check("reset_data", {rd_xaddr, rd_yaddr, rd_zaddr, rd_fidx, rd_first, rd_last}, 32'd0);
            end
            if (done === 1'b1) done_cnt++;
        end
        if (rst === 1'b1) begin
            m_known = 1'b1; m_phase = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; exp_zero = 1'b1;
        end else if (m_known) begin
            exp_zero = 1'b0;
            case (m_phase)
                0: begin
                    exp_done = 1'b0;
                    if (start) begin
                        build_beats(int'(x_inp), int'(y_inp), int'(z_inp), int'(cfg_stride), int'(cfg_nout));
                        m_idx = 0; job_hs = 0;
                        if (m_total == 0) begin
                            m_phase = 2; exp_done = 1'b1;
                        end else begin
                            m_phase = 1; exp_busy = 1'b1; exp_valid = 1'b1;
                        end
                    end
                end
                1: begin
                    if (rd_ready) begin
                        ox[m_idx] = int'(rd_xaddr); oy[m_idx] = int'(rd_yaddr); oz[m_idx] = int'(rd_zaddr);
                        of_[m_idx] = int'(rd_fidx); ofirst[m_idx] = int'(rd_first); olast[m_idx] = int'(rd_last);
                        job_hs++; m_idx++;
                        if (m_idx == m_total) begin
                            m_phase = 2; exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b1;
                        end
                    end
                end
                default: begin
                    m_phase = 0; exp_done = 1'b0;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic run_job(input int x, input int y, input int z, input int s, input int nout,
                           input bit rnd, input int mid_start_at);
        int cyc;
        @(posedge clk); #1;
        x_inp = AW'(x); y_inp = AW'(y); z_inp = ZW'(z); cfg_stride = 4'(s); cfg_nout = ZW'(nout);
        start = 1'b1;
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_inp = AW'($urandom); y_inp = AW'($urandom); z_inp = ZW'($urandom);
        cfg_stride = 4'($urandom); cfg_nout = ZW'($urandom);
        cyc = 0;
        while (m_phase != 0 && cyc < BUDGET) begin
            start = (cyc == mid_start_at) ? 1'b1 : 1'b0;
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("job_completes", 32'(m_phase), 32'd0);
    endtask

    int d0;

    initial begin
        // 1: reset with toggling start and random inputs
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            x_inp = AW'($urandom); y_inp = AW'($urandom); z_inp = ZW'($urandom);
            cfg_stride = 4'($urandom); cfg_nout = ZW'($urandom); rd_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        // 2: defaults, ready held high
        d0 = done_cnt;
        run_job(64, 0, 0, 1, 2, 1'b0, -1);
        check("t2_beats", 32'(job_hs), 32'd128);
        check("t2_b0_x", 32'(ox[0]), 32'd64);
        check("t2_b0_y", 32'(oy[0]), 32'd0);
        check("t2_b0_z", 32'(oz[0]), 32'd0);
        check("t2_b0_first", 32'(ofirst[0]), 32'd1);
        check("t2_b16_x", 32'(ox[16]), 32'd65);
        check("t2_b16_z", 32'(oz[16]), 32'd1);
        check("t2_b32_x", 32'(ox[32]), 32'd64);
        check("t2_b32_y", 32'(oy[32]), 32'd16);
        check("t2_b32_z", 32'(oz[32]), 32'd2);
        check("t2_b32_f", 32'(of_[32]), 32'd1);
        check("t2_b127_x", 32'(ox[127]), 32'd80);
        check("t2_b127_y", 32'(oy[127]), 32'd63);
        check("t2_b127_z", 32'(oz[127]), 32'd7);
        check("t2_b127_last", 32'(olast[127]), 32'd1);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 3: same config, random backpressure
        d0 = done_cnt;
        run_job(64, 0, 0, 1, 2, 1'b1, -1);
        check("t3_beats", 32'(job_hs), 32'd128);
        check("t3_b127_x", 32'(ox[127]), 32'd80);
        check("t3_b16_x", 32'(ox[16]), 32'd65);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 4: stride 2, nout 3, second start mid-run ignored
        run_job(10, 0, 0, 2, 3, 1'b0, 5);
        check("t4_beats", 32'(job_hs), 32'd192);
        check("t4_o2k0_x", 32'(ox[32]), 32'd14);
        run_job(64, 0, 0, 0, 2, 1'b1, -1);
        check("t4_s0_b16_x", 32'(ox[16]), 32'd65);
        check("t4_s0_b31_x", 32'(ox[31]), 32'd80);

        // 5: boundaries
        d0 = done_cnt;
        run_job(64, 0, 0, 1, 0, 1'b0, -1);
        check("t5_nout0_beats", 32'(job_hs), 32'd0);
        check("t5_nout0_done", 32'(done_cnt - d0), 32'd1);
        run_job(500, 0, 0, 1, 1, 1'b0, -1);
        check("t5_xwrap", 32'(ox[15]), 32'd3);
        run_job(0, 0, 250, 1, 4, 1'b0, -1);
        check("t5_zwrap", 32'(oz[128]), 32'd2);

        // 6: reset at beat 40, then a clean run
        d0 = done_cnt;
        @(posedge clk); #1;
        x_inp = 9'd64; y_inp = 9'd0; z_inp = 8'd0; cfg_stride = 4'd1; cfg_nout = 8'd2;
        start = 1'b1; rd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < BUDGET && job_hs < 40; c++) begin
            @(posedge clk); #1;
        end
        check("t6_reached_beat40", 32'(job_hs), 32'd40);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_valid_after_rst", 32'(rd_valid), 32'd0);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        run_job(64, 0, 0, 1, 2, 1'b0, -1);
        check("t6_beats", 32'(job_hs), 32'd128);
        check("t6_b0_x", 32'(ox[0]), 32'd64);
        check("t6_b127_z", 32'(oz[127]), 32'd7);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
